// File: rtl/bin2qdi_token_sched.sv
// Round-robin scheduler that shares one e1of1 binary-to-QDI source between N_REQ requesters.
// Define BIN2QDI_SCHED_STATS_EN to add the stat_tokens / stat_timeouts counters.
module bin2qdi_token_sched #(
   parameter int N_REQ       = 4,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TO_W        = 16,
   parameter int TO_LIMIT    = 1000,
   localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   CLK,
   input  logic                   RESETn,
   input  logic [N_REQ-1:0]       rq_valid,
   input  logic [N_REQ*CNT_W-1:0] rq_count,
   output logic [N_REQ-1:0]       rq_ready,
   output logic [N_REQ-1:0]       rq_done,
   output logic                   rq_err,
   output logic                   req,
   output logic                   din,
   input  logic                   R_mon,
   input  logic                   Re,
   output logic                   busy,
   output logic [ID_W-1:0]        grant_id,
   output logic [CNT_W-1:0]       remaining
`ifdef BIN2QDI_SCHED_STATS_EN
   ,
   output logic [N_REQ*32-1:0]    stat_tokens,
   output logic [15:0]            stat_timeouts
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARB     = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_WAIT_RH = 3'd3,
      ST_WAIT_RL = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   localparam logic [N_REQ-1:0] ONE_LSB  = N_REQ'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1'b1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

   logic [SYNC_STAGES-1:0] r_sync_r;
   logic [SYNC_STAGES-1:0] re_sync_r;
   logic                   r_s;
   logic                   re_s;

   state_t            state_r;
   state_t            state_nx_s;
   logic [ID_W-1:0]   ptr_r;
   logic [ID_W-1:0]   ptr_nx_s;
   logic [ID_W-1:0]   grant_r;
   logic [ID_W-1:0]   grant_nx_s;
   logic [CNT_W-1:0]  rem_r;
   logic [CNT_W-1:0]  rem_nx_s;
   logic              req_r;
   logic              req_nx_s;
   logic              din_r;
   logic              din_nx_s;
   logic              busy_r;
   logic [N_REQ-1:0]  ready_r;
   logic [N_REQ-1:0]  ready_nx_s;
   logic [N_REQ-1:0]  done_r;
   logic [N_REQ-1:0]  done_nx_s;
   logic              err_r;
   logic              err_nx_s;
   logic              abort_r;
   logic              abort_nx_s;
   logic [TO_W-1:0]   to_cnt_r;
   logic [TO_W-1:0]   to_cnt_nx_s;
   logic              to_hit_s;
   logic              tok_done_s;
   logic              to_abort_s;

   logic              hi_found_s;
   logic              lo_found_s;
   logic [ID_W-1:0]   hi_idx_s;
   logic [ID_W-1:0]   lo_idx_s;
   logic [ID_W-1:0]   pick_idx_s;
   logic [CNT_W-1:0]  pick_count_s;

   // Two synchronizer chains bringing the asynchronous R and Re into the clock domain
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_sync_r  <= '0;
         re_sync_r <= '0;
      end else begin
         r_sync_r  <= {r_sync_r[SYNC_STAGES-2:0], R_mon};
         re_sync_r <= {re_sync_r[SYNC_STAGES-2:0], Re};
      end
   end

   assign r_s  = r_sync_r[SYNC_STAGES-1];
   assign re_s = re_sync_r[SYNC_STAGES-1];

   // Round-robin pick: lowest valid index at or above the pointer, else lowest valid overall
   always_comb begin
      hi_found_s = 1'b0;
      lo_found_s = 1'b0;
      hi_idx_s   = '0;
      lo_idx_s   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rq_valid[k]) begin
            lo_found_s = 1'b1;
            lo_idx_s   = ID_W'(k);
            if (k >= int'(ptr_r)) begin
               hi_found_s = 1'b1;
               hi_idx_s   = ID_W'(k);
            end else begin
               hi_found_s = hi_found_s;
               hi_idx_s   = hi_idx_s;
            end
         end else begin
            lo_found_s = lo_found_s;
            lo_idx_s   = lo_idx_s;
         end
      end
      pick_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
      pick_count_s = rq_count[int'(pick_idx_s) * CNT_W +: CNT_W];
   end

   assign to_hit_s = (to_cnt_r == TO_LAST);

   // Next-state and next-register logic for the scheduler FSM
   always_comb begin
      state_nx_s = state_r;
      ptr_nx_s   = ptr_r;
      grant_nx_s = grant_r;
      rem_nx_s   = rem_r;
      req_nx_s   = req_r;
      din_nx_s   = din_r;
      ready_nx_s = '0;
      done_nx_s  = '0;
      err_nx_s   = 1'b0;
      abort_nx_s = abort_r;
      tok_done_s = 1'b0;
      to_abort_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // The grant is registered on the way into ARB so rq_ready is a clean flop output there
            if (lo_found_s) begin
               state_nx_s = ST_ARB;
               ready_nx_s = ONE_LSB << pick_idx_s;
               grant_nx_s = pick_idx_s;
               rem_nx_s   = pick_count_s;
               din_nx_s   = 1'b1;
               abort_nx_s = 1'b0;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ARB: begin
            if (rem_r == '0) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (re_s && !r_s) begin
               req_nx_s   = 1'b1;
               state_nx_s = ST_WAIT_RH;
            end else if (to_hit_s) begin
               req_nx_s   = 1'b0;
               abort_nx_s = 1'b1;
               to_abort_s = 1'b1;
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_ISSUE;
            end
         end
         ST_WAIT_RH: begin
            if (r_s) begin
               req_nx_s   = 1'b0;
               rem_nx_s   = rem_r - CNT_ONE;
               tok_done_s = 1'b1;
               state_nx_s = ST_WAIT_RL;
            end else if (to_hit_s) begin
               req_nx_s   = 1'b0;
               abort_nx_s = 1'b1;
               to_abort_s = 1'b1;
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_WAIT_RH;
            end
         end
         ST_WAIT_RL: begin
            if (!r_s) begin
               state_nx_s = (rem_r == '0) ? ST_DONE : ST_ISSUE;
            end else if (to_hit_s) begin
               abort_nx_s = 1'b1;
               to_abort_s = 1'b1;
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_WAIT_RL;
            end
         end
         ST_DONE: begin
            done_nx_s  = ONE_LSB << grant_r;
            err_nx_s   = abort_r;
            ptr_nx_s   = (grant_r == ID_LAST) ? '0 : grant_r + ID_W'(1'b1);
            din_nx_s   = 1'b0;
            state_nx_s = ST_IDLE;
         end
         default: begin
            req_nx_s   = 1'b0;
            din_nx_s   = 1'b0;
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Phase timeout counter: restarts on every state change, runs only while waiting on the source
   always_comb begin
      to_cnt_nx_s = '0;
      if (state_nx_s != state_r) begin
         to_cnt_nx_s = '0;
      end else if ((state_r == ST_ISSUE) || (state_r == ST_WAIT_RH) || (state_r == ST_WAIT_RL)) begin
         to_cnt_nx_s = to_cnt_r + TO_ONE;
      end else begin
         to_cnt_nx_s = '0;
      end
   end

   // FSM state and all output registers
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_r  <= ST_IDLE;
         ptr_r    <= '0;
         grant_r  <= '0;
         rem_r    <= '0;
         req_r    <= 1'b0;
         din_r    <= 1'b0;
         busy_r   <= 1'b0;
         ready_r  <= '0;
         done_r   <= '0;
         err_r    <= 1'b0;
         abort_r  <= 1'b0;
         to_cnt_r <= '0;
      end else begin
         state_r  <= state_nx_s;
         ptr_r    <= ptr_nx_s;
         grant_r  <= grant_nx_s;
         rem_r    <= rem_nx_s;
         req_r    <= req_nx_s;
         din_r    <= din_nx_s;
         busy_r   <= (state_nx_s != ST_IDLE);
         ready_r  <= ready_nx_s;
         done_r   <= done_nx_s;
         err_r    <= err_nx_s;
         abort_r  <= abort_nx_s;
         to_cnt_r <= to_cnt_nx_s;
      end
   end

   assign rq_ready  = ready_r;
   assign rq_done   = done_r;
   assign rq_err    = err_r;
   assign req       = req_r;
   assign din       = din_r;
   assign busy      = busy_r;
   assign grant_id  = grant_r;
   assign remaining = rem_r;

`ifdef BIN2QDI_SCHED_STATS_EN
   logic [N_REQ*32-1:0] stat_tok_r;
   logic [15:0]         stat_to_r;

   // Saturating per-requester token counters and a global timeout counter
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         stat_tok_r <= '0;
         stat_to_r  <= '0;
      end else begin
         if (tok_done_s && (stat_tok_r[int'(grant_r)*32 +: 32] != 32'hFFFF_FFFF)) begin
            stat_tok_r[int'(grant_r)*32 +: 32] <= stat_tok_r[int'(grant_r)*32 +: 32] + 32'd1;
         end
         if (to_abort_s && (stat_to_r != 16'hFFFF)) begin
            stat_to_r <= stat_to_r + 16'd1;
         end
      end
   end

   assign stat_tokens   = stat_tok_r;
   assign stat_timeouts = stat_to_r;
`else
   logic stats_unused_s;
   assign stats_unused_s = tok_done_s ^ to_abort_s;
`endif

endmodule
